// File: rtl/level_pkg.sv
// Shared state encoding and sizing helpers for the level sequencer.
package level_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PASSED = 3'd3,
    ST_FAILED = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // ROM words per level: the object table followed by one target-score word.
  function automatic int stride(input int objects, input int words_per_object);
    return objects * words_per_object + 1;
  endfunction

  // Address width for a memory of the given depth; never narrower than 1 bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Seconds countdown: loads a start value, decrements on tick unless held,
// and stops at zero.
module countdown_timer #(
  parameter int TIME_W = 7
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              load,
  input  logic [TIME_W-1:0] load_value,
  input  logic              tick,
  input  logic              hold,
  output logic              zero,
  output logic [TIME_W-1:0] count
);

  logic [TIME_W-1:0] r_count;
  logic              w_zero;

  assign w_zero = (r_count == {TIME_W{1'b0}});
  assign zero   = w_zero;
  assign count  = r_count;

  // Count register: load wins, otherwise decrement on an unheld tick above zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= {TIME_W{1'b0}};
    end else if (load) begin
      r_count <= load_value;
    end else if (tick && !hold && !w_zero) begin
      r_count <= r_count - TIME_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Level sequencer: loads each level's object table and target from ROM,
// runs the level against a countdown, scores it, and steps through levels.
module level_sequencer
  import level_pkg::*;
#(
  parameter int NUM_LEVELS       = 4,
  parameter int OBJECTS_COUNT    = 20,
  parameter int WORDS_PER_OBJECT = 3,
  parameter int WORD_W           = 9,
  parameter int MAX_TIME         = 60,
  parameter int TIME_W           = 7,
  parameter int SCORE_W          = 16
) (
  input  logic                                                            clk,
  input  logic                                                            resetN,
  input  logic                                                            enable,
  input  logic                                                            cycleLevel,
  input  logic                                                            oneSecPulse,
  input  logic [OBJECTS_COUNT-1:0]                                        objCollected,
  input  logic                                                            scoreAdd,
  input  logic [SCORE_W-1:0]                                              scoreValue,
  output logic [addr_w(NUM_LEVELS*stride(OBJECTS_COUNT,WORDS_PER_OBJECT))-1:0] memAddr,
  input  logic [WORD_W-1:0]                                               memData,
  output logic [OBJECTS_COUNT*WORDS_PER_OBJECT*WORD_W-1:0]                objData,
  output logic [OBJECTS_COUNT-1:0]                                        objValid,
  output logic [addr_w(NUM_LEVELS)-1:0]                                   levelIdx,
  output logic [TIME_W-1:0]                                               timer,
  output logic [SCORE_W-1:0]                                              score,
  output logic                                                            loading,
  output logic                                                            playing,
  output logic                                                            stagePassed,
  output logic                                                            stageFailed,
  output logic                                                            lastLevelEnded
);

  localparam int STRIDE = stride(OBJECTS_COUNT, WORDS_PER_OBJECT);
  localparam int ADDR_W = addr_w(NUM_LEVELS * STRIDE);
  localparam int LVL_W  = addr_w(NUM_LEVELS);
  localparam int CNT_W  = addr_w(STRIDE + 1);
  localparam int OBJ_W  = OBJECTS_COUNT * WORDS_PER_OBJECT * WORD_W;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_enable_d;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [OBJ_W-1:0]       r_obj_data;
  logic [OBJECTS_COUNT-1:0] r_obj_valid;
  logic [LVL_W-1:0]       r_level;
  logic [SCORE_W-1:0]     r_score;
  logic [SCORE_W-1:0]     r_snapshot;
  logic [SCORE_W-1:0]     r_target;
  logic                   r_loading;
  logic                   r_playing;
  logic                   r_passed;
  logic                   r_failed;
  logic                   r_last_ended;

  logic                   w_en_rise;
  logic                   w_last;
  logic                   w_play_end;
  logic                   w_load_entry;
  logic                   w_tick;
  logic                   w_hold;
  logic                   w_timer_zero;
  logic [TIME_W-1:0]      w_timer;
  logic [SCORE_W:0]       w_sum;
  logic [SCORE_W-1:0]     w_score_next;
  logic [SCORE_W-1:0]     w_snap_next;
  logic [LVL_W-1:0]       w_level_next;
  logic [ADDR_W-1:0]      w_base;

  assign w_en_rise    = enable & ~r_enable_d;
  assign w_last       = (r_level == LVL_W'(NUM_LEVELS - 1));
  assign w_play_end   = w_timer_zero || (r_obj_valid == {OBJECTS_COUNT{1'b0}});
  assign w_load_entry = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);
  // The LOAD-to-PLAY cycle is still LOAD, so a tick arriving then is dropped.
  assign w_tick       = oneSecPulse && (r_state == ST_PLAY) && !w_play_end;
  assign w_hold       = ~enable;
  assign w_snap_next  = (r_state == ST_PASSED) ? r_score : r_snapshot;
  assign w_level_next = (w_load_entry && (r_state == ST_PASSED)) ? (r_level + LVL_W'(1)) : r_level;
  assign w_base       = ADDR_W'(w_level_next) * ADDR_W'(STRIDE);

  countdown_timer #(
    .TIME_W(TIME_W)
  ) u_timer (
    .clk        (clk),
    .resetN     (resetN),
    .load       (w_load_entry),
    .load_value (TIME_W'(MAX_TIME)),
    .tick       (w_tick),
    .hold       (w_hold),
    .zero       (w_timer_zero),
    .count      (w_timer)
  );

  // Saturating score update; adds are ignored while loading.
  always_comb begin
    w_sum        = {1'b0, r_score} + {1'b0, scoreValue};
    w_score_next = r_score;
    if (scoreAdd && (r_state != ST_LOAD)) begin
      if (w_sum[SCORE_W]) begin
        w_score_next = {SCORE_W{1'b1}};
      end else begin
        w_score_next = w_sum[SCORE_W-1:0];
      end
    end else begin
      w_score_next = r_score;
    end
  end

  // Next-state logic for the level flow.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_en_rise) w_state_next = ST_LOAD;
        else           w_state_next = ST_IDLE;
      end
      ST_LOAD: begin
        if (r_cnt == CNT_W'(STRIDE)) w_state_next = ST_PLAY;
        else                         w_state_next = ST_LOAD;
      end
      ST_PLAY: begin
        if (w_play_end) begin
          if (w_score_next >= r_target) w_state_next = ST_PASSED;
          else                          w_state_next = ST_FAILED;
        end else begin
          w_state_next = ST_PLAY;
        end
      end
      ST_PASSED: begin
        if (w_last)          w_state_next = ST_DONE;
        else if (cycleLevel) w_state_next = ST_LOAD;
        else                 w_state_next = ST_PASSED;
      end
      ST_FAILED: begin
        if (cycleLevel) w_state_next = ST_LOAD;
        else            w_state_next = ST_FAILED;
      end
      ST_DONE: w_state_next = ST_DONE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Datapath: ROM fetch, object table, score bookkeeping and status flags.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      // Edge detector starts high so an enable already high at reset release
      // does not count as a rising edge.
      r_enable_d   <= 1'b1;
      r_cnt        <= {CNT_W{1'b0}};
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_obj_data   <= {OBJ_W{1'b0}};
      r_obj_valid  <= {OBJECTS_COUNT{1'b0}};
      r_level      <= {LVL_W{1'b0}};
      r_score      <= {SCORE_W{1'b0}};
      r_snapshot   <= {SCORE_W{1'b0}};
      r_target     <= {SCORE_W{1'b0}};
      r_loading    <= 1'b0;
      r_playing    <= 1'b0;
      r_passed     <= 1'b0;
      r_failed     <= 1'b0;
      r_last_ended <= 1'b0;
    end else begin
      r_enable_d <= enable;
      r_loading  <= (w_state_next == ST_LOAD);
      r_playing  <= (w_state_next == ST_PLAY);
      r_passed   <= (r_state == ST_PLAY) && (w_state_next == ST_PASSED);
      r_failed   <= (r_state == ST_PLAY) && (w_state_next == ST_FAILED);
      r_level    <= w_level_next;

      if ((r_state == ST_PASSED) && (w_state_next == ST_DONE)) r_last_ended <= 1'b1;
      else                                                     r_last_ended <= r_last_ended;

      if (w_load_entry && (r_state == ST_PASSED)) r_snapshot <= r_score;
      else                                        r_snapshot <= r_snapshot;

      if (w_load_entry) r_score <= w_snap_next;
      else              r_score <= w_score_next;

      if (w_load_entry) begin
        r_cnt       <= {CNT_W{1'b0}};
        r_mem_addr  <= w_base;
        r_obj_valid <= {OBJECTS_COUNT{1'b1}};
      end else if (r_state == ST_LOAD) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt < CNT_W'(STRIDE - 1)) r_mem_addr <= r_mem_addr + ADDR_W'(1);
        else                            r_mem_addr <= r_mem_addr;
        // Data arrives one cycle behind its address, so word k lands at count k+1.
        if (r_cnt == CNT_W'(STRIDE)) begin
          r_target <= SCORE_W'(memData);
        end else if (r_cnt != {CNT_W{1'b0}}) begin
          r_obj_data[(int'(r_cnt) - 1) * WORD_W +: WORD_W] <= memData;
        end else begin
          r_target <= r_target;
        end
      end else if ((r_state == ST_PLAY) && enable && !w_play_end) begin
        r_obj_valid <= r_obj_valid & ~objCollected;
      end else begin
        r_obj_valid <= r_obj_valid;
      end
    end
  end

  assign memAddr        = r_mem_addr;
  assign objData        = r_obj_data;
  assign objValid       = r_obj_valid;
  assign levelIdx       = r_level;
  assign timer          = w_timer;
  assign score          = r_score;
  assign loading        = r_loading;
  assign playing        = r_playing;
  assign stagePassed    = r_passed;
  assign stageFailed    = r_failed;
  assign lastLevelEnded = r_last_ended;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer with two levels of two objects,
// a three-second timer and a target score of 10 on each level.
module tb_level_sequencer;

  localparam int STRIDE = 7;
  localparam int TARGET = 10;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic        cycleLevel = 1'b0;
  logic        oneSecPulse = 1'b0;
  logic [1:0]  objCollected = 2'b00;
  logic        scoreAdd = 1'b0;
  logic [15:0] scoreValue = 16'd0;
  logic [3:0]  memAddr;
  logic [8:0]  memData = 9'd0;
  logic [53:0] objData;
  logic [1:0]  objValid;
  logic [0:0]  levelIdx;
  logic [6:0]  timer;
  logic [15:0] score;
  logic        loading, playing, stagePassed, stageFailed, lastLevelEnded;

  level_sequencer #(
    .NUM_LEVELS(2), .OBJECTS_COUNT(2), .WORDS_PER_OBJECT(3), .WORD_W(9),
    .MAX_TIME(3), .TIME_W(7), .SCORE_W(16)
  ) dut (
    .clk(clk), .resetN(resetN), .enable(enable), .cycleLevel(cycleLevel),
    .oneSecPulse(oneSecPulse), .objCollected(objCollected), .scoreAdd(scoreAdd),
    .scoreValue(scoreValue), .memAddr(memAddr), .memData(memData), .objData(objData),
    .objValid(objValid), .levelIdx(levelIdx), .timer(timer), .score(score),
    .loading(loading), .playing(playing), .stagePassed(stagePassed),
    .stageFailed(stageFailed), .lastLevelEnded(lastLevelEnded)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle later.
  logic [8:0] rom [16];
  always @(posedge clk) memData <= rom[memAddr];

  typedef struct {
    int          kind;   // 0 = level entered play, 1 = passed, 2 = failed
    int          lvl;
    logic [15:0] sc;
    logic [6:0]  tm;
    logic [1:0]  ov;
    logic [53:0] od;
    int          addr;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state of the game, kept in plain integers.
  int m_level, m_score, m_snap, m_timer;
  logic [1:0] m_obj;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [53:0] level_objs(input int lvl);
    logic [53:0] r;
    r = '0;
    for (int w = 0; w < 6; w++) r[w*9 +: 9] = rom[lvl*STRIDE + w];
    return r;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT enters play or pulses a result.
  int   mon_load_cnt = 0;
  int   mon_first_addr = 0;
  logic mon_prev_play = 1'b0;
  logic mon_prev_load = 1'b0;
  always @(negedge clk) begin
    exp_t me;
    if (!resetN) begin
      mon_load_cnt  = 0;
      mon_prev_play = 1'b0;
      mon_prev_load = 1'b0;
    end else begin
      if (loading) begin
        if (!mon_prev_load) begin
          mon_load_cnt   = 0;
          mon_first_addr = int'(memAddr);
        end
        mon_load_cnt++;
      end
      if (playing && !mon_prev_play) begin
        if (q.size() == 0) begin
          chk("unexpected_play", 64'd1, 64'd0);
        end else begin
          me = q.pop_front();
          chk("play_kind", 64'(me.kind), 64'd0);
          chk("load_cycles", 64'(mon_load_cnt), 64'(STRIDE + 1));
          chk("load_first_addr", 64'(mon_first_addr), 64'(me.addr));
          chk("play_level", 64'(levelIdx), 64'(me.lvl));
          chk("play_timer", 64'(timer), 64'(me.tm));
          chk("play_objvalid", 64'(objValid), 64'(me.ov));
          chk("play_objdata", 64'(objData), 64'(me.od));
          chk("play_score", 64'(score), 64'(me.sc));
        end
      end
      if (stagePassed || stageFailed) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          me = q.pop_front();
          chk("result_kind", stagePassed ? 64'd1 : (stageFailed ? 64'd2 : 64'd0), 64'(me.kind));
          chk("result_single", 64'(stagePassed & stageFailed), 64'd0);
          chk("result_level", 64'(levelIdx), 64'(me.lvl));
          chk("result_score", 64'(score), 64'(me.sc));
          chk("result_timer", 64'(timer), 64'(me.tm));
          chk("result_objvalid", 64'(objValid), 64'(me.ov));
        end
      end
      mon_prev_play = playing;
      mon_prev_load = loading;
    end
  end

  // One DUT cycle with the given inputs; pulses are cleared afterwards.
  task automatic cyc(input logic p, input logic a, input logic [15:0] v,
                     input logic [1:0] c, input logic cl);
    oneSecPulse = p; scoreAdd = a; scoreValue = v; objCollected = c; cycleLevel = cl;
    @(negedge clk);
    oneSecPulse = 1'b0; scoreAdd = 1'b0; scoreValue = 16'd0; objCollected = 2'b00; cycleLevel = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_memaddr", 64'(memAddr), 64'd0);
    chk("rst_objdata", 64'(objData), 64'd0);
    chk("rst_objvalid", 64'(objValid), 64'd0);
    chk("rst_level", 64'(levelIdx), 64'd0);
    chk("rst_timer", 64'(timer), 64'd0);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_flags", {59'd0, loading, playing, stagePassed, stageFailed, lastLevelEnded}, 64'd0);
  endtask

  // Start a level (enable edge or cycleLevel); ticks and adds during load are ignored.
  task automatic begin_level(input bit via_cycle);
    exp_t e;
    int k;
    m_timer = 3; m_obj = 2'b11; m_score = m_snap;
    e.kind = 0; e.lvl = m_level; e.sc = 16'(m_snap); e.tm = 7'd3; e.ov = 2'b11;
    e.od = level_objs(m_level); e.addr = m_level * STRIDE;
    q.push_back(e);
    if (via_cycle) cycleLevel = 1'b1;
    else           enable = 1'b1;
    oneSecPulse = 1'b1;
    @(negedge clk);
    cycleLevel = 1'b0;
    scoreAdd = 1'b1; scoreValue = 16'd7;
    k = 0;
    while (!playing && k < 20) begin
      @(negedge clk);
      k++;
    end
    oneSecPulse = 1'b0; scoreAdd = 1'b0; scoreValue = 16'd0;
    if (!playing) chk("load_timeout", 64'd0, 64'd1);
  endtask

  // Play one attempt under the given stimulus mode; returns the predicted outcome.
  task automatic play(input int mode, output bit passed);
    exp_t e;
    int n, r, k;
    bit fin;
    logic p, a, en, cl;
    logic [15:0] v;
    logic [1:0] c;
    fin = 1'b0; n = 0;
    while (!fin && n < 100) begin
      p = 1'b0; a = 1'b0; v = 16'd0; c = 2'b00; cl = 1'b0; en = 1'b1;
      case (mode)
        1: begin if (n == 0) begin a = 1'b1; v = 16'd5; end else p = 1'b1; end
        2: begin
          if (n == 0) begin a = 1'b1; v = 16'd10; end
          else if (n == 1) p = 1'b1;
          else c = 2'b11;
        end
        3: begin if (n == 0) begin a = 1'b1; v = 16'd12; end else p = 1'b1; end
        default: begin
          r = $urandom_range(0, 9);
          if (r <= 2) p = 1'b1;
          else if (r <= 4) begin a = 1'b1; v = 16'($urandom_range(0, 5)); end
          else if (r == 5) c = 2'b01 << $urandom_range(0, 1);
          else if (r == 6) begin
            en = 1'b0; p = 1'b1; c = 2'($urandom_range(0, 3));
            a = 1'b1; v = 16'($urandom_range(0, 5));
          end
          else if (r == 7) cl = 1'b1;
        end
      endcase
      if (a) m_score = sat_add(m_score, int'(v));
      if (en) begin
        if (p && m_timer > 0) m_timer--;
        m_obj = m_obj & ~c;
      end
      enable = en;
      cyc(p, a, v, c, cl);
      n++;
      if (m_timer == 0 || m_obj == 2'b00) fin = 1'b1;
    end
    enable = 1'b1;
    a = 1'b0; v = 16'd0;
    if (mode == 0) begin
      a = 1'($urandom_range(0, 1)); v = 16'($urandom_range(0, 6));
      if (a) m_score = sat_add(m_score, int'(v));
    end
    passed = (m_score >= TARGET);
    e.kind = passed ? 1 : 2; e.lvl = m_level; e.sc = 16'(m_score);
    e.tm = 7'(m_timer); e.ov = m_obj; e.od = '0; e.addr = 0;
    q.push_back(e);
    cyc(1'b0, a, v, 2'b00, 1'b0);
    k = 0;
    while (!(stagePassed || stageFailed) && k < 5) begin
      @(negedge clk);
      k++;
    end
    if (!(stagePassed || stageFailed)) chk("result_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int modes0 [4];
    bit passed;
    for (int i = 0; i < 16; i++) rom[i] = 9'($urandom);
    rom[STRIDE - 1]     = 9'(TARGET);
    rom[2 * STRIDE - 1] = 9'(TARGET);
    modes0 = '{1, 0, 0, 2};
    m_level = 0; m_snap = 0; m_score = 0; m_timer = 0; m_obj = 2'b00;

    // Reset with enable already high: no level may start afterwards.
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    resetN = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_start_without_low", 64'(loading | playing), 64'd0);
    enable = 1'b0;
    @(negedge clk);

    // Level 0: fail on timeout, random attempts, then pass by collecting all.
    begin_level(1'b0);
    passed = 1'b0;
    for (int i = 0; i < 4 && !passed; i++) begin
      play(modes0[i], passed);
      if (!passed) begin_level(1'b1);
    end
    if (!passed) begin
      play(3, passed);
    end

    // Advance to level 1 and pass it on timeout with a healthy score.
    m_snap = m_score;
    m_level = 1;
    begin_level(1'b1);
    play(3, passed);
    repeat (2) @(negedge clk);
    chk("done_last_flag", 64'(lastLevelEnded), 64'd1);
    chk("done_not_playing", 64'(playing | loading), 64'd0);

    // DONE ignores cycleLevel and a fresh enable edge.
    cyc(1'b0, 1'b0, 16'd0, 2'b00, 1'b1);
    enable = 1'b0;
    cyc(1'b0, 1'b0, 16'd0, 2'b00, 1'b0);
    enable = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 16'd0, 2'b00, 1'b1);
    chk("done_ignores_load", 64'(loading | playing), 64'd0);
    chk("done_level_held", 64'(levelIdx), 64'd1);
    chk("done_flag_sticky", 64'(lastLevelEnded), 64'd1);

    // Reset in the middle of play abandons the level silently.
    resetN = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    m_level = 0; m_snap = 0;
    begin_level(1'b0);
    cyc(1'b1, 1'b0, 16'd0, 2'b01, 1'b0);
    #2 resetN = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_pulse_after_reset", 64'(stagePassed | stageFailed | loading), 64'd0);
    end

    // Score saturates at the top of its range.
    cyc(1'b0, 1'b1, 16'hFFF0, 2'b00, 1'b0);
    chk("score_add", 64'(score), 64'hFFF0);
    cyc(1'b0, 1'b1, 16'hFFFF, 2'b00, 1'b0);
    chk("score_saturate", 64'(score), 64'hFFFF);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
 - NUM_LEVELS, 4, number of levels in the level ROM
 - OBJECTS_COUNT, 20, objects per level
 - WORDS_PER_OBJECT, 3, ROM words per object (x, y, type)
 - WORD_W, 9, ROM word width
 - MAX_TIME, 60, level time in seconds
 - TIME_W, 7, timer width
 - SCORE_W, 16, score width
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
 - clk  in  1  single clock for the whole block
 - resetN  in  1  asynchronous, active-low reset
 - enable  in  1  level run enable; a rising edge starts a level; low pauses play
 - cycleLevel  in  1  one-cycle pulse that advances after a pass or retries after a fail
 - oneSecPulse  in  1  one-cycle tick, once per second
 - objCollected  in  OBJECTS_COUNT  one-cycle pulses; bit i means object i was grabbed
 - scoreAdd  in  1  one-cycle pulse to add scoreValue to the score
 - scoreValue  in  SCORE_W  amount added when scoreAdd is high
 - memAddr  out  clog2(NUM_LEVELS*STRIDE)  registered ROM address
 - memData  in  WORD_W  ROM data, valid one cycle after memAddr
 - objData  out  OBJECTS_COUNT*WORDS_PER_OBJECT*WORD_W  active level object table
 - objValid  out  OBJECTS_COUNT  object still present on the field
 - levelIdx  out  clog2(NUM_LEVELS)  current level number
 - timer  out  TIME_W  seconds remaining
 - score  out  SCORE_W  accumulated score
 - loading  out  1  high while in LOAD
 - playing  out  1  high while in PLAY
 - stagePassed  out  1  one-cycle pulse when a level is passed
 - stageFailed  out  1  one-cycle pulse when a level is failed
 - lastLevelEnded  out  1  sticky flag, set when the last level is passed

Function
REQ-003 STRIDE SHALL be OBJECTS_COUNT*WORDS_PER_OBJECT+1; level L occupies ROM words L*STRIDE to L*STRIDE+STRIDE-1, and the final word of each level is that level's target score, zero-extended.
REQ-004 The FSM SHALL have exactly these states: IDLE, LOAD, PLAY, PASSED, FAILED, DONE.
REQ-005 In IDLE, a rising edge of enable SHALL move the FSM to LOAD; a level enable with no preceding low SHALL NOT start a level.
REQ-006 LOAD SHALL issue one address per cycle. Each memData word SHALL be captured one cycle after its address. LOAD SHALL last exactly STRIDE+1 cycles and then enter PLAY.
REQ-007 On LOAD entry the block SHALL set timer to MAX_TIME, set objValid to all-ones, and copy the level-start score snapshot into score.
REQ-008 In PLAY with enable high:
 - each oneSecPulse SHALL decrement timer by 1;
 - timer SHALL NOT go below 0;
 - an objCollected bit SHALL clear the matching objValid bit.
REQ-009 In PLAY with enable low, timer and objValid SHALL hold their values; scoreAdd SHALL still be accepted.
REQ-010 Score SHALL add scoreValue on scoreAdd in any state except LOAD, saturating at 2^SCORE_W-1.
REQ-011 PLAY SHALL end in the first cycle in which timer==0 or objValid==0. The next state SHALL be PASSED if the score, including any same-cycle add, is at least the target; otherwise it SHALL be FAILED.
REQ-012 stagePassed or stageFailed SHALL pulse high for exactly one cycle, on entry to PASSED or FAILED respectively.
REQ-013 PASSED on the last level SHALL move directly to DONE and set lastLevelEnded. Otherwise, cycleLevel SHALL increment levelIdx, store the current score as the new level-start snapshot, and enter LOAD.
REQ-014 In FAILED, cycleLevel SHALL re-enter LOAD on the same level with the score restored to the snapshot.
REQ-015 DONE SHALL be terminal until reset; cycleLevel and enable SHALL be ignored in DONE.
REQ-016 cycleLevel in IDLE, LOAD or PLAY SHALL be ignored.
REQ-017 A oneSecPulse arriving in the same cycle as the LOAD-to-PLAY transition SHALL be ignored.

Reset
REQ-018 When resetN is low, all state SHALL clear asynchronously:
 - FSM goes to IDLE;
 - levelIdx, score, snapshot, timer, memAddr, objData, objValid, and all flags go to 0.
REQ-019 Reset asserted during LOAD or PLAY SHALL abandon the level with no pass or fail pulse.

Structure
REQ-020 Package level_pkg SHALL hold the state enum, the STRIDE function, and the address-width helper.
REQ-021 The timer SHALL be a sub-module countdown_timer with load, tick, hold and zero ports; all other logic SHALL be in level_sequencer.

Verification
All scenarios use OBJECTS_COUNT=2, NUM_LEVELS=2, MAX_TIME=3, and target word 10.
REQ-022 Rising edge of enable in IDLE -> loading high for 8 cycles, objData equals ROM words 0-5, then playing high with timer=3.
REQ-023 Three oneSecPulses with score=12 -> timer reaches 0, one stagePassed pulse; cycleLevel -> levelIdx=1 and memAddr begins at 7.
REQ-024 Score 5 at timeout -> one stageFailed pulse; cycleLevel -> level reloads and score returns to the snapshot.
REQ-025 objCollected=2'b11 with score 10 at timer=2 -> immediate PASSED; timer holds at 2.
REQ-026 Pass on level 1 -> lastLevelEnded=1, state DONE; later cycleLevel and enable cause no change.
REQ-027 resetN low in mid-PLAY -> all outputs 0 and no pass/fail pulse; scoreAdd of 0xFFFF on score 0xFFF0 -> score=0xFFFF.
